// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        live;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  // True when a live destination matches a non-zero register query.
  function automatic logic rd_hit(input logic live, input logic [4:0] rd, input logic [4:0] q);
    return live && (rd == q) && (q != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline/multi-cycle unit/hazard unit and the write-port arbiter.
interface wb_port_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  qry_rs;
  logic [4:0]  qry_rt;
  logic        busy_rs;
  logic        busy_rt;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  modport master (
    output wb_we, wb_rd, wb_data, md_valid, md_rd, md_data, qry_rs, qry_rt,
    input  md_ready, busy_rs, busy_rt, stall_req, rf_we, rf_wa, rf_wd
  );

  modport slave (
    input  wb_we, wb_rd, wb_data, md_valid, md_rd, md_data, qry_rs, qry_rt,
    output md_ready, busy_rs, busy_rt, stall_req, rf_we, rf_wa, rf_wd
  );
endinterface

// File: rtl/wb_fifo.sv
// Small circular buffer of multi-cycle results with per-slot kill of the live bit.
module wb_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        push_entry,
  input  logic [DEPTH-1:0] kill,
  output wb_entry_t        head_entry,
  output logic [DEPTH-1:0] live_o,
  output logic [4:0]       rd_o [DEPTH],
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(32'd1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Next storage contents: a popped slot goes dead so only occupied live slots report busy
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (tail_q == PW'(i))) begin
        mem_d[i] = push_entry;
      end else begin
        mem_d[i]      = mem_q[i];
        mem_d[i].live = mem_q[i].live && !kill[i] && !(pop && (head_q == PW'(i)));
      end
    end
  end

  // Pointer and occupancy update
  always_comb begin
    head_d = pop  ? head_q + PTR_ONE : head_q;
    tail_d = push ? tail_q + PTR_ONE : tail_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{live: 1'b0, rd: REG_ZERO, data: 32'd0};
      end
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Status and per-slot views
  always_comb begin
    head_entry = mem_q[head_q];
    full       = (count_q == CNT_FULL);
    empty      = (count_q == {CW{1'b0}});
    for (int i = 0; i < DEPTH; i++) begin
      live_o[i] = mem_q[i].live;
      rd_o[i]   = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port: pipeline writeback first, buffered multi-cycle
// results drained on idle cycles, with hazard reporting and a starvation stall request.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  wb_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] CNT_ONE = SW'(32'd1);

  logic             pipe_own_s, push_s, pop_s, full_s, empty_s;
  logic             busy_rs_s, busy_rt_s;
  wb_entry_t        push_entry_s, head_entry_s;
  logic [DEPTH-1:0] live_s, kill_s;
  logic [4:0]       rd_s [DEPTH];
  logic [SW-1:0]    starve_d, starve_q;
  logic             stall_d, stall_q;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .pop        (pop_s),
    .push_entry (push_entry_s),
    .kill       (kill_s),
    .head_entry (head_entry_s),
    .live_o     (live_s),
    .rd_o       (rd_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  // Ownership, admission, and killing of buffered writes that the pipeline supersedes
  always_comb begin
    pipe_own_s = bus.wb_we && (bus.wb_rd != REG_ZERO);
    pop_s      = !pipe_own_s && !empty_s;
    push_s     = bus.md_valid && !full_s;
    push_entry_s.live = (bus.md_rd != REG_ZERO) && !(pipe_own_s && (bus.md_rd == bus.wb_rd));
    push_entry_s.rd   = bus.md_rd;
    push_entry_s.data = bus.md_data;
    for (int i = 0; i < DEPTH; i++) begin
      kill_s[i] = pipe_own_s && rd_hit(live_s[i], rd_s[i], bus.wb_rd);
    end
  end

  // Write-port mux
  always_comb begin
    if (pipe_own_s) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = bus.wb_rd;
      bus.rf_wd = bus.wb_data;
    end else if (pop_s && head_entry_s.live) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = head_entry_s.rd;
      bus.rf_wd = head_entry_s.data;
    end else begin
      bus.rf_we = 1'b0;
      bus.rf_wa = REG_ZERO;
      bus.rf_wd = 32'd0;
    end
  end

  // Hazard compare over stored live entries plus the push arriving this cycle
  always_comb begin
    busy_rs_s = rd_hit(push_s, bus.md_rd, bus.qry_rs);
    busy_rt_s = rd_hit(push_s, bus.md_rd, bus.qry_rt);
    for (int i = 0; i < DEPTH; i++) begin
      busy_rs_s = busy_rs_s | rd_hit(live_s[i], rd_s[i], bus.qry_rs);
      busy_rt_s = busy_rt_s | rd_hit(live_s[i], rd_s[i], bus.qry_rt);
    end
  end

  // Starvation count: a non-empty FIFO that does not pop is blocked by the pipeline
  always_comb begin
    if (empty_s || pop_s) begin
      starve_d = {SW{1'b0}};
    end else if (starve_q != LIMIT_C) begin
      starve_d = starve_q + CNT_ONE;
    end else begin
      starve_d = starve_q;
    end
    stall_d = (starve_d == LIMIT_C);
  end

  // Starvation state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= {SW{1'b0}};
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.md_ready  = !full_s;
  assign bus.busy_rs   = busy_rs_s;
  assign bus.busy_rt   = busy_rt_s;
  assign bus.stall_req = stall_q;

endmodule
